logic_seq_ctrl: RTL and testbench

LOGIC_SEQ_CTRL -- requirements
Module: logic_seq_ctrl

---
 rtl/logic_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_logic_seq_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/logic_seq_ctrl.sv
// logic_seq_ctrl: programmable bit-sequencer applying one stored opcode to
// x_in/y_in every INTERVAL cycles, with a registered result z and change strobe.
// Optional looping mode is enabled by defining LSEQ_LOOP_EN (adds the loop port).
module logic_seq_ctrl #(
  parameter int unsigned INTERVAL = 10,
  parameter int unsigned DEPTH    = 16
) (
`ifdef LSEQ_LOOP_EN
  input  logic       loop,
`endif
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       x_in,
  input  logic       y_in,
  input  logic       prog_we,
  input  logic [3:0] prog_addr,
  input  logic [2:0] prog_op,
  input  logic [4:0] prog_len,
  output logic       z,
  output logic       z_chg,
  output logic       busy,
  output logic       done,
  output logic [3:0] step_idx
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(INTERVAL - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       step_q, step_d;
  logic [4:0]       len_q, len_d;
  logic             z_q, z_d;
  logic             z_chg_q, z_chg_d;
  logic             busy_q, busy_d;
  logic             fin_q, fin_d;
  logic             done_q;

  logic [2:0]       mem_q [DEPTH];
  logic [2:0]       op_c;
  logic             dec_c;
  logic             last_c;
  logic             loop_c;

`ifdef LSEQ_LOOP_EN
  assign loop_c = loop;
`else
  assign loop_c = 1'b0;
`endif

  // Program memory: writable only in IDLE, deliberately not reset.
  always_ff @(posedge clk) begin
    if (prog_we && (state_q == S_IDLE) && (32'(prog_addr) < DEPTH)) begin
      mem_q[prog_addr] <= prog_op;
    end
  end

  // Opcode fetch and decode for the current step.
  always_comb begin
    op_c  = 3'd7;
    dec_c = z_q;
    if (32'(step_q) < DEPTH) begin
      op_c = mem_q[step_q];
    end
    case (op_c)
      3'd0:    dec_c = ~x_in;
      3'd1:    dec_c = x_in | y_in;
      3'd2:    dec_c = x_in ^ y_in;
      3'd3:    dec_c = x_in & y_in;
      3'd4:    dec_c = y_in;
      3'd5:    dec_c = 1'b0;
      3'd6:    dec_c = 1'b1;
      default: dec_c = z_q;
    endcase
  end

  assign last_c = ({1'b0, step_q} == (len_q - 5'd1));

  // Next-state and output logic; done is staged through fin one cycle late.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    len_d   = len_q;
    z_d     = z_q;
    z_chg_d = 1'b0;
    fin_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (prog_len == 5'd0) begin
            fin_d = 1'b1;
          end else if (prog_len <= 5'd16) begin
            state_d = S_RUN;
            len_d   = prog_len;
            step_d  = 4'd0;
            cnt_d   = RELOAD;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          z_d     = dec_c;
          z_chg_d = (dec_c != z_q);
          cnt_d   = RELOAD;
          if (last_c) begin
            step_d = 4'd0;
            if (!loop_c) begin
              state_d = S_IDLE;
              fin_d   = 1'b1;
            end
          end else begin
            step_d = step_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      len_q   <= '0;
      z_q     <= 1'b0;
      z_chg_q <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      len_q   <= len_d;
      z_q     <= z_d;
      z_chg_q <= z_chg_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
      done_q  <= fin_q;
    end
  end

  assign z        = z_q;
  assign z_chg    = z_chg_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign step_idx = step_q;

endmodule

// File: tb/tb_logic_seq_ctrl.sv
// Directed bench for logic_seq_ctrl; observed vector is {z, z_chg, busy, done, step_idx}.
module tb_logic_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       x_in = 1'b0;
  logic       y_in = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [2:0] prog_op = '0;
  logic [4:0] prog_len = '0;
  logic       z, z_chg, busy, done;
  logic [3:0] step_idx;
`ifdef LSEQ_LOOP_EN
  logic       loop = 1'b0;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  logic_seq_ctrl #(.INTERVAL(10), .DEPTH(16)) dut (
`ifdef LSEQ_LOOP_EN
    .loop      (loop),
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .x_in      (x_in),
    .y_in      (y_in),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_op   (prog_op),
    .prog_len  (prog_len),
    .z         (z),
    .z_chg     (z_chg),
    .busy      (busy),
    .done      (done),
    .step_idx  (step_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] obs();
    return {z, z_chg, busy, done, step_idx};
  endfunction

  task automatic prog(input logic [3:0] a, input logic [2:0] op);
    prog_we = 1'b1; prog_addr = a; prog_op = op;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Start a run at edge 0 and check every cycle against the hand-written z table.
  task automatic run_seq(input int id, input int len, input logic [7:0] zexp, input logic zstart);
    int n;
    logic ez, pz, ec, eb, ed;
    logic [3:0] es;
    start = 1'b1; prog_len = 5'(len);
    tick();
    start = 1'b0;
    for (int c = 0; c <= len * 10 + 2; c++) begin
      if (c > 0) tick();
      n  = (c / 10 > len) ? len : c / 10;
      ez = (n == 0) ? zstart : zexp[n-1];
      pz = (n <= 1) ? zstart : zexp[n-2];
      ec = (c % 10 == 0) && (c >= 10) && (c / 10 <= len) && (ez != pz);
      eb = (c < len * 10);
      ed = (c == len * 10 + 1);
      es = (c < len * 10) ? 4'(c / 10) : 4'd0;
      check($sformatf("run%0d_c%0d", id, c), 32'(obs()), 32'({ez, ec, eb, ed, es}));
    end
  endtask

  initial begin
    tick();
    check("reset_outputs", 32'(obs()), 32'h0);
    rst_n = 1'b1;

    // Ops 0,1,6,2 with x=0,y=1 all give 1: one z_chg at cycle 10, done at 41.
    prog(4'd0, 3'd0); prog(4'd1, 3'd1); prog(4'd2, 3'd6); prog(4'd3, 3'd2);
    x_in = 1'b0; y_in = 1'b1;
    run_seq(1, 4, 8'b0000_1111, 1'b0);

    // Toggle program from z=0: no strobe at 10.
    do_reset();
    check("post_reset_z", 32'(z), 32'h0);
    prog(4'd0, 3'd5); prog(4'd1, 3'd6); prog(4'd2, 3'd5); prog(4'd3, 3'd6);
    run_seq(2, 4, 8'b0000_1010, 1'b0);

    // Remaining opcodes with x=1,y=0: 6,3,6,4,6,7 -> 1,0,1,0,1,1.
    x_in = 1'b1; y_in = 1'b0;
    prog(4'd0, 3'd6); prog(4'd1, 3'd3); prog(4'd2, 3'd6);
    prog(4'd3, 3'd4); prog(4'd4, 3'd6); prog(4'd5, 3'd7);
    run_seq(3, 6, 8'b0011_0101, 1'b1);

    // Abort during an 8-step run.
    for (int i = 0; i < 8; i++) prog(4'(i), (i % 2 == 0) ? 3'd6 : 3'd5);
    start = 1'b1; prog_len = 5'd8;
    tick();
    start = 1'b0;
    repeat (25) tick();
    check("abort_pre_c25", 32'(obs()), 32'({1'b0, 1'b0, 1'b1, 1'b0, 4'd2}));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_c26", 32'(obs()), 32'({1'b0, 1'b0, 1'b0, 1'b0, 4'd2}));
    for (int i = 0; i < 15; i++) begin
      tick();
      check($sformatf("abort_idle_%0d", i), 32'(obs()), 32'({1'b0, 1'b0, 1'b0, 1'b0, 4'd2}));
    end

    // Zero-length start: done one cycle late, no busy, z unchanged.
    do_reset();
    start = 1'b1; prog_len = 5'd0;
    tick();
    start = 1'b0;
    check("len0_c0", 32'(obs()), 32'h0);
    tick();
    check("len0_done", 32'(obs()), 32'h10);
    tick();
    check("len0_c2", 32'(obs()), 32'h0);

    // Abort wins over start in IDLE.
    start = 1'b1; abort = 1'b1; prog_len = 5'd4;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_prio_c0", 32'(obs()), 32'h0);
    tick();
    check("abort_prio_c1", 32'(obs()), 32'h0);

    // Program write during RUN is ignored: mem1 stays op0 (~x = 0).
    prog(4'd0, 3'd6); prog(4'd1, 3'd0);
    start = 1'b1; prog_len = 5'd2;
    tick();
    start = 1'b0;
    repeat (5) tick();
    prog(4'd1, 3'd6);
    repeat (4) tick();
    check("we_run_c10", 32'(obs()), 32'({1'b1, 1'b1, 1'b1, 1'b0, 4'd1}));
    repeat (10) tick();
    check("we_run_c20", 32'(obs()), 32'({1'b0, 1'b1, 1'b0, 1'b0, 4'd0}));
    tick();
    check("we_run_done", 32'(obs()), 32'({1'b0, 1'b0, 1'b0, 1'b1, 4'd0}));

    // Reset mid-run clears everything at once; no done afterwards.
    prog(4'd1, 3'd6);
    start = 1'b1; prog_len = 5'd4;
    tick();
    start = 1'b0;
    repeat (15) tick();
    check("rst_mid_c15", 32'(obs()), 32'({1'b1, 1'b0, 1'b1, 1'b0, 4'd1}));
    rst_n = 1'b0;
    #1;
    check("rst_mid_async", 32'(obs()), 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    check("rst_mid_idle", 32'(obs()), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("rst_mid_after_%0d", i), 32'(obs()), 32'h0);
    end

`ifdef LSEQ_LOOP_EN
    // Looping len=2 run: z alternates every 10 cycles, never done.
    prog(4'd0, 3'd6); prog(4'd1, 3'd5);
    loop = 1'b1;
    start = 1'b1; prog_len = 5'd2;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      repeat (10) tick();
      check($sformatf("loop_step%0d", k), 32'(obs()),
            32'({(k % 2 == 1), 1'b1, 1'b1, 1'b0, ((k % 2 == 1) ? 4'd1 : 4'd0)}));
    end
    loop = 1'b0;
    repeat (10) tick();
    check("loop_last", 32'(obs()), 32'({1'b0, 1'b1, 1'b0, 1'b0, 4'd0}));
    tick();
    check("loop_done", 32'(obs()), 32'({1'b0, 1'b0, 1'b0, 1'b1, 4'd0}));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
